// File: rtl/async_pkg.sv
// Shared types and constants for the clocked-to-asynchronous dual-rail link blocks.
package async_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        NULL = 2'd2
    } tx_state_t;

    localparam int RAIL_NUM = 2;
    localparam int RAIL_T   = 1;
    localparam int RAIL_F   = 0;

    localparam logic [15:0] ENC_TP = "TP";
    localparam logic [15:0] ENC_FP = "FP";

    // One-hot rail pair for a single data bit: true rail for 1, false rail for 0.
    function automatic logic [RAIL_NUM-1:0] rail_onehot(input logic bit_val);
        logic [RAIL_NUM-1:0] r;
        r = '0;
        if (bit_val) r[RAIL_T] = 1'b1;
        else         r[RAIL_F] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/ack_sync.sv
// Two-flop synchronizer for a single asynchronous level entering the clk domain.
module ack_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], din};
        end
    end

    assign dout = sync_reg[1];

endmodule

// File: rtl/sync_tx.sv
// Synchronous-to-dual-rail transmitter: one word per handshake, two-phase or four-phase RZ.
module sync_tx
    import async_pkg::*;
#(
    parameter logic [15:0] ENC   = ENC_TP,
    parameter int          WIDTH = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   in_data,
    output logic [WIDTH-1:0][RAIL_NUM-1:0]     out,
    input  logic                               ack_i,
    output logic                               busy
);

    logic                           ack_s;
    logic                           ack_ph_reg;
    tx_state_t                      state_reg;
    logic [WIDTH-1:0][RAIL_NUM-1:0] rails_reg;
    logic [WIDTH-1:0][RAIL_NUM-1:0] rails_accept;
    logic [WIDTH-1:0][RAIL_NUM-1:0] rails_exit;
    tx_state_t                      data_exit_state;
    logic                           settled;
    logic                           ack_moved;

    ack_sync u_ack_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (ack_i),
        .dout (ack_s)
    );

    generate
        if (ENC == ENC_TP) begin : g_tp
            for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
                assign rails_accept[gi] = rails_reg[gi] ^ rail_onehot(in_data[gi]);
            end
            assign rails_exit      = rails_reg;
            assign data_exit_state = IDLE;
        end else if (ENC == ENC_FP) begin : g_fp
            for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
                assign rails_accept[gi] = rail_onehot(in_data[gi]);
            end
            assign rails_exit      = '0;
            assign data_exit_state = NULL;
        end else begin : g_bad
            $error("sync_tx: ENC must be \"TP\" or \"FP\"");
            assign rails_accept    = '0;
            assign rails_exit      = '0;
            assign data_exit_state = IDLE;
        end
    endgenerate

    // ack_ph holds the ack level the FSM expects to see next time it is idle.
    // In FP it is 0 in IDLE/DATA and 1 in NULL, so both encodings share the
    // same "settled" and "ack moved" tests.
    assign settled   = (ack_s == ack_ph_reg);
    assign ack_moved = (ack_s != ack_ph_reg);

    assign in_ready = (state_reg == IDLE) && settled;
    assign busy     = (state_reg != IDLE);
    assign out      = rails_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            ack_ph_reg <= 1'b0;
            rails_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        rails_reg <= rails_accept;
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (ack_moved) begin
                        ack_ph_reg <= ack_s;
                        rails_reg  <= rails_exit;
                        state_reg  <= data_exit_state;
                    end
                end
                NULL: begin
                    if (ack_moved) begin
                        ack_ph_reg <= ack_s;
                        state_reg  <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_tx.sv
// Directed bench for sync_tx: a two-phase 4-bit instance and a four-phase 8-bit instance.
module tb_sync_tx;

    logic       clk;
    logic       rst_n;

    logic       tp_valid, tp_ready, tp_ack, tp_busy;
    logic [3:0] tp_data;
    logic [3:0][1:0] tp_out;

    logic       fp_valid, fp_ready, fp_ack, fp_busy;
    logic [7:0] fp_data;
    logic [7:0][1:0] fp_out;

    int vectors;
    int miscompares;

    sync_tx #(.ENC("TP"), .WIDTH(4)) u_tp (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(tp_valid),
        .in_ready(tp_ready),
        .in_data (tp_data),
        .out     (tp_out),
        .ack_i   (tp_ack),
        .busy    (tp_busy)
    );

    sync_tx #(.ENC("FP"), .WIDTH(8)) u_fp (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(fp_valid),
        .in_ready(fp_ready),
        .in_data (fp_data),
        .out     (fp_out),
        .ack_i   (fp_ack),
        .busy    (fp_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fp;
        logic [7:0]  data;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two-phase token: accept, toggle ack, expect IDLE exactly three edges later.
    task automatic tp_token(input logic [3:0] d, input logic [7:0] exp_out, input string tag);
        check({tag, " ready_before"}, 32'(tp_ready), 32'd1);
        tp_valid = 1'b1;
        tp_data  = d;
        step();
        tp_valid = 1'b0;
        tp_data  = 4'($urandom);
        check({tag, " out_accept"}, 32'(tp_out), 32'(exp_out));
        check({tag, " busy_accept"}, 32'(tp_busy), 32'd1);
        check({tag, " ready_accept"}, 32'(tp_ready), 32'd0);
        tp_ack = ~tp_ack;
        step();
        check({tag, " ready_e1"}, 32'(tp_ready), 32'd0);
        step();
        check({tag, " ready_e2"}, 32'(tp_ready), 32'd0);
        step();
        check({tag, " ready_e3"}, 32'(tp_ready), 32'd1);
        check({tag, " busy_e3"}, 32'(tp_busy), 32'd0);
        check({tag, " out_held"}, 32'(tp_out), 32'(exp_out));
        $display("TP token data=%b out=%h ack=%b", d, tp_out, tp_ack);
    endtask

    // Four-phase token: data phase, ack rise clears rails, ack fall returns to IDLE.
    task automatic fp_token(input logic [7:0] d, input logic [15:0] exp_out, input string tag);
        check({tag, " ready_before"}, 32'(fp_ready), 32'd1);
        fp_valid = 1'b1;
        fp_data  = d;
        step();
        fp_valid = 1'b0;
        fp_data  = 8'($urandom);
        check({tag, " out_accept"}, 32'(fp_out), 32'(exp_out));
        check({tag, " busy_accept"}, 32'(fp_busy), 32'd1);
        check({tag, " ready_accept"}, 32'(fp_ready), 32'd0);
        fp_ack = 1'b1;
        step();
        step();
        check({tag, " out_e2"}, 32'(fp_out), 32'(exp_out));
        step();
        check({tag, " out_null"}, 32'(fp_out), 32'd0);
        check({tag, " ready_null"}, 32'(fp_ready), 32'd0);
        check({tag, " busy_null"}, 32'(fp_busy), 32'd1);
        fp_ack = 1'b0;
        step();
        step();
        check({tag, " ready_e5"}, 32'(fp_ready), 32'd0);
        step();
        check({tag, " ready_e6"}, 32'(fp_ready), 32'd1);
        check({tag, " busy_e6"}, 32'(fp_busy), 32'd0);
        $display("FP token data=%h out=%h", d, exp_out);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n    = 1'b0;
        tp_valid = 1'b0; tp_data = '0; tp_ack = 1'b0;
        fp_valid = 1'b0; fp_data = '0; fp_ack = 1'b0;

        // true rail = upper bit of each pair, bit 0 in the low pair
        vecs[0] = '{1'b0, 8'h0A, 16'h0099};
        vecs[1] = '{1'b0, 8'h0A, 16'h0000};
        vecs[2] = '{1'b0, 8'h06, 16'h0069};
        vecs[3] = '{1'b0, 8'h0F, 16'h00C3};
        vecs[4] = '{1'b0, 8'h00, 16'h0096};
        vecs[5] = '{1'b1, 8'hA5, 16'h9966};
        vecs[6] = '{1'b1, 8'h00, 16'h5555};
        vecs[7] = '{1'b1, 8'hFF, 16'hAAAA};
        vecs[8] = '{1'b1, 8'h3C, 16'h5AA5};

        step();
        check("reset tp_out", 32'(tp_out), 32'd0);
        check("reset tp_busy", 32'(tp_busy), 32'd0);
        check("reset fp_out", 32'(fp_out), 32'd0);
        check("reset fp_busy", 32'(fp_busy), 32'd0);
        rst_n = 1'b1;
        step();
        step();
        check("reset tp_ready", 32'(tp_ready), 32'd1);
        check("reset fp_ready", 32'(fp_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].fp)
                fp_token(vecs[i].data, vecs[i].exp_out, $sformatf("vec%0d", i));
            else
                tp_token(vecs[i].data[3:0], vecs[i].exp_out[7:0], $sformatf("vec%0d", i));
        end
        check("tp ack level after table", 32'(tp_ack), 32'd1);

        // in_valid held high with changing data while the token is in flight
        tp_valid = 1'b1;
        tp_data  = 4'b0011;
        step();
        tp_data = 4'($urandom);
        check("hold out_accept", 32'(tp_out), 32'h00CC);
        tp_ack = ~tp_ack;
        for (int k = 1; k <= 3; k++) begin
            tp_data = 4'($urandom);
            step();
            check($sformatf("hold out_e%0d", k), 32'(tp_out), 32'h00CC);
            check($sformatf("hold ready_e%0d", k), 32'(tp_ready), (k == 3) ? 32'd1 : 32'd0);
        end
        tp_valid = 1'b0;
        step();
        check("hold no_second_accept", 32'(tp_busy), 32'd0);
        $display("TP hold-valid token out=%h", tp_out);

        // reset while a two-phase token waits in DATA
        tp_valid = 1'b1;
        tp_data  = 4'b1010;
        step();
        tp_valid = 1'b0;
        check("rst_tp out_accept", 32'(tp_out), 32'h0055);
        check("rst_tp busy_accept", 32'(tp_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_tp out_async", 32'(tp_out), 32'd0);
        check("rst_tp busy_async", 32'(tp_busy), 32'd0);
        tp_ack = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        tp_token(4'b0110, 8'h69, "rst_tp after");
        $display("TP reset-in-DATA recovered out=%h", tp_out);

        // reset while a four-phase token sits in NULL
        tp_ack   = 1'b0;
        fp_valid = 1'b1;
        fp_data  = 8'hA5;
        step();
        fp_valid = 1'b0;
        fp_ack = 1'b1;
        step();
        step();
        step();
        check("rst_fp busy_null", 32'(fp_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_fp out_async", 32'(fp_out), 32'd0);
        check("rst_fp busy_async", 32'(fp_busy), 32'd0);
        fp_ack = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        fp_token(8'h0F, 16'h55AA, "rst_fp after");
        $display("FP reset-in-NULL recovered");

        // spurious ack toggle in IDLE: rails frozen, FSM stays idle
        tp_token(4'b1100, 8'hA5, "pre_desync");
        tp_ack = ~tp_ack;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("desync out_e%0d", k), 32'(tp_out), 32'h00A5);
            check($sformatf("desync busy_e%0d", k), 32'(tp_busy), 32'd0);
        end
        $display("TP spurious ack in IDLE out=%h busy=%b", tp_out, tp_busy);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
